mismatch_window_counter: RTL and testbench
==========================================

# mismatch_window_counter

Downstream consumer of the serial "current bit differs from the bit two samples back" detector. Takes the detector's 1-bit mismatch flag and counts mismatches over fixed windows of WIN_LEN valid samples. Raises a threshold alarm per window and tracks the longest run of consecutive mismatches. Each window result is handed off through a hold-until-ack register.

## Interface
- WIN_LEN, 16: valid samples per window; ≥2.
- THRESH, 4: alarm when window mismatch count ≥ THRESH; 1..WIN_LEN.
- CNT_W, 5: counter/result width; must satisfy 2^CNT_W > WIN_LEN.
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high.
- in  input  1  mismatch flag from upstream detector.
- in_valid  input  1  in is meaningful this cycle. Upstream holds it low until two bits are primed.
- ack  input  1  consumer has taken the current result.
- count  output  CNT_W  mismatch count of last reported window.
- max_run  output  CNT_W  longest consecutive-mismatch run in last reported window.
- count_valid  output  1  result registers hold an unconsumed window.
- alarm  output  1  reported window met threshold; qualified by count_valid.
- overrun  output  1  sticky: a completed window was dropped.

## Operation
- FSM states:
  - IDLE: after reset. First cycle with in_valid=1 → COUNT; that sample is counted as sample 1.
  - COUNT: remains here until reset.
- Sample accounting: only in_valid=1 cycles advance the sample counter (sidx) and the mismatch counter (acc). in_valid=0 cycles freeze all window state.
- Run tracking:
  - A valid in=1 increments cur_run; a valid in=0 zeroes it.
  - best_run = max(best_run, updated cur_run) on each valid sample.
  - Runs do not span window boundaries.
- Window completion: on the valid sample where sidx reaches WIN_LEN:
  - Final values include that sample.
  - sidx, acc, cur_run and best_run restart at 0 for the next sample.
- Result load happens when a window completes and either count_valid=0 or ack=1 the same cycle:
  - count ← final acc.
  - max_run ← final best_run.
  - alarm ← (final acc ≥ THRESH).
  - count_valid ← 1.
- Drop: the window completes while count_valid=1 and ack=0:
  - Result registers are unchanged.
  - overrun ← 1.
  - Counting continues normally into the next window.
- ack with count_valid=1 and no simultaneous completion: count_valid ← 0 and alarm ← 0. count and max_run keep their stale values.
- ack while count_valid=0: ignored.
- Arithmetic: all counters are unsigned CNT_W bits and never wrap; the parameter rule above guarantees this.
- overrun is cleared only by reset.

## Timing
- Reset values (cycle after reset sampled high):
  - All outputs 0.
  - FSM in IDLE; sidx, acc and runs all 0.
- Reset mid-window: the partial window is discarded; the next valid sample after reset is sample 1.
- Latency: count_valid rises, with the result, the cycle after the clock edge that accepted the WIN_LEN-th sample.
- Handshake:
  - Results are held stable while count_valid=1 until the edge where ack=1 is sampled.
  - Back-to-back windows with ack asserted on the completion cycle keep count_valid high continuously; there is no bubble.
- Simultaneous events:
  - Completion + ack: the new result loads, count_valid stays 1, no overrun.
  - reset overrides everything.
- Throughput: one sample per cycle, no stalls; in is never back-pressured.

## Configuration
- MISMATCH_WIN_MAXRUN_EN defined: cur_run/best_run logic is built and max_run is driven as above.
- Undefined:
  - Run logic is removed.
  - max_run is tied to 0.
  - All other behaviour is identical.

## Test plan
- Window with alarm (WIN_LEN=16, THRESH=4; all scenarios use these values):
  - Stimulus: reset, then 16 consecutive valid samples with in=1 at samples 3, 4, 5 and 10, no ack.
  - Required: one cycle after sample 16, count=4, max_run=3, alarm=1, count_valid=1.
  - Required: outputs hold stable for 20 idle cycles.
- Gaps: same 16 samples interleaved with in_valid=0 cycles, where in=1 during the gaps → count=4 and sample count unaffected by the gap cycles.
- Continuous ack: ack asserted on every completion cycle for 3 windows with 0, 16 and 3 mismatches.
  - Required: count_valid stays 1 throughout; count sequence 0, 16, 3; alarm 0, 1, 0; overrun=0.
  - Required: max_run=16 for the all-ones window.
- Overrun: complete window A (5 mismatches), never ack, complete window B (9 mismatches).
  - Required: count=5 retained and overrun=1.
  - Then ack → count_valid=0 with overrun still 1.
- Reset mid-window: 10 valid samples (all in=1), assert reset for 1 cycle, then 16 samples of in=0.
  - Required: all outputs 0 after reset.
  - Required: next result count=0, max_run=0, alarm=0.
- Build without MISMATCH_WIN_MAXRUN_EN, repeating the first scenario → max_run=0, count=4, alarm=1.

Source files
------------

// File: rtl/mismatch_window_counter_if.sv
// Sample/result bundle for mismatch_window_counter.
//   master : upstream detector + result consumer (drives in, in_valid, ack)
//   slave  : the counter itself (drives count, max_run, count_valid, alarm, overrun)
// Signals:
//   in          mismatch flag from the upstream detector
//   in_valid    in is meaningful this cycle
//   ack         consumer has taken the current result
//   count       mismatch count of the last reported window
//   max_run     longest consecutive-mismatch run in the last reported window
//   count_valid result registers hold an unconsumed window
//   alarm       reported window met the threshold (qualified by count_valid)
//   overrun     sticky: a completed window was dropped
interface mismatch_window_counter_if #(
  parameter int unsigned CNT_W = 5
);
  logic             in;
  logic             in_valid;
  logic             ack;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] max_run;
  logic             count_valid;
  logic             alarm;
  logic             overrun;

  modport master (
    output in, in_valid, ack,
    input  count, max_run, count_valid, alarm, overrun
  );

  modport slave (
    input  in, in_valid, ack,
    output count, max_run, count_valid, alarm, overrun
  );
endinterface

// File: rtl/mismatch_window_counter.sv
// Counts upstream mismatch flags over windows of WIN_LEN valid samples, flags windows whose
// count reaches THRESH, and hands each window result off through a hold-until-ack register.
// Ports:
//   clk    sole clock, rising edge
//   reset  synchronous, active-high; overrides everything
//   bus    mismatch_window_counter_if.slave (in, in_valid, ack -> count, max_run,
//          count_valid, alarm, overrun)
// Build option:
//   MISMATCH_WIN_MAXRUN_EN  defined: longest-run tracking is built and drives max_run.
//                           undefined: run logic is removed and max_run is tied to 0.
module mismatch_window_counter #(
  parameter int unsigned WIN_LEN = 16,
  parameter int unsigned THRESH  = 4,
  parameter int unsigned CNT_W   = 5
) (
  input logic                      clk,
  input logic                      reset,
  mismatch_window_counter_if.slave bus
);

  typedef enum logic {StIdle, StCount} state_e;

  state_e state_q, state_d;

  // Window accumulation
  logic [CNT_W-1:0] sidx_q, sidx_d, sidx_inc;
  logic [CNT_W-1:0] acc_q, acc_d, acc_inc;
  logic             win_done;

  // Result hand-off registers
  logic [CNT_W-1:0] count_q, count_d;
  logic             count_valid_q, count_valid_d;
  logic             alarm_q, alarm_d;
  logic             overrun_q, overrun_d;
  logic             load;

  // FSM: IDLE only marks "no sample seen since reset"; the first valid sample is counted
  // in the same cycle it moves us to COUNT, so counting itself never depends on the state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.in_valid) state_d = StCount;
      StCount: state_d = StCount;
      default: state_d = StIdle;
    endcase
  end

  assign sidx_inc = sidx_q + 1'b1;
  assign acc_inc  = acc_q + {{(CNT_W-1){1'b0}}, bus.in};
  assign win_done = bus.in_valid && (sidx_inc == CNT_W'(WIN_LEN));

  always_comb begin
    sidx_d = sidx_q;
    acc_d  = acc_q;
    if (bus.in_valid) begin
      if (win_done) begin
        sidx_d = '0;
        acc_d  = '0;
      end else begin
        sidx_d = sidx_inc;
        acc_d  = acc_inc;
      end
    end
  end

`ifdef MISMATCH_WIN_MAXRUN_EN
  logic [CNT_W-1:0] cur_run_q, cur_run_d, cur_run_upd;
  logic [CNT_W-1:0] best_run_q, best_run_d, best_run_upd;
  logic [CNT_W-1:0] max_run_q, max_run_d;

  assign cur_run_upd  = bus.in ? (cur_run_q + 1'b1) : '0;
  assign best_run_upd = (cur_run_upd > best_run_q) ? cur_run_upd : best_run_q;

  // Runs restart at window boundaries, so the final best includes the closing sample.
  always_comb begin
    cur_run_d  = cur_run_q;
    best_run_d = best_run_q;
    max_run_d  = max_run_q;
    if (bus.in_valid) begin
      if (win_done) begin
        cur_run_d  = '0;
        best_run_d = '0;
      end else begin
        cur_run_d  = cur_run_upd;
        best_run_d = best_run_upd;
      end
    end
    if (load) max_run_d = best_run_upd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_run_q  <= '0;
      best_run_q <= '0;
      max_run_q  <= '0;
    end else begin
      cur_run_q  <= cur_run_d;
      best_run_q <= best_run_d;
      max_run_q  <= max_run_d;
    end
  end

  assign bus.max_run = max_run_q;
`else
  assign bus.max_run = '0;
`endif

  // A completed window loads if the slot is free or being freed this cycle; otherwise it
  // is dropped and the sticky overrun is raised.
  assign load = win_done && (!count_valid_q || bus.ack);

  always_comb begin
    count_d       = count_q;
    count_valid_d = count_valid_q;
    alarm_d       = alarm_q;
    overrun_d     = overrun_q;
    if (load) begin
      count_d       = acc_inc;
      alarm_d       = (acc_inc >= CNT_W'(THRESH));
      count_valid_d = 1'b1;
    end else if (win_done) begin
      overrun_d = 1'b1;
    end else if (bus.ack && count_valid_q) begin
      // count keeps its stale value after consumption
      count_valid_d = 1'b0;
      alarm_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      sidx_q        <= '0;
      acc_q         <= '0;
      count_q       <= '0;
      count_valid_q <= 1'b0;
      alarm_q       <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sidx_q        <= sidx_d;
      acc_q         <= acc_d;
      count_q       <= count_d;
      count_valid_q <= count_valid_d;
      alarm_q       <= alarm_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bus.count       = count_q;
  assign bus.count_valid = count_valid_q;
  assign bus.alarm       = alarm_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_mismatch_window_counter.sv
// Bench for mismatch_window_counter: a queue-based window model checked every cycle, plus
// hand-computed literal expectations for each directed scenario.
module tb_mismatch_window_counter;

  localparam int unsigned WIN_LEN = 16;
  localparam int unsigned THRESH  = 4;
  localparam int unsigned CNT_W   = 5;
`ifdef MISMATCH_WIN_MAXRUN_EN
  localparam bit MrEn = 1'b1;
`else
  localparam bit MrEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  mismatch_window_counter_if #(.CNT_W(CNT_W)) bus ();

  mismatch_window_counter #(
    .WIN_LEN(WIN_LEN),
    .THRESH (THRESH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: samples of the open window kept in a queue ----------------
  bit q_win[$];
  int m_count, m_mr;
  bit m_cv, m_alarm, m_ovr, m_en;

  function automatic int win_sum();
    int s;
    s = 0;
    foreach (q_win[i]) s += int'(q_win[i]);
    return s;
  endfunction

  function automatic int win_maxrun();
    int best, run;
    best = 0;
    run  = 0;
    foreach (q_win[i]) begin
      run  = q_win[i] ? run + 1 : 0;
      best = (run > best) ? run : best;
    end
    return best;
  endfunction

  always @(posedge clk) begin
    int  s, r;
    bit  done;
    if (reset) begin
      q_win.delete();
      m_count = 0;
      m_mr    = 0;
      m_cv    = 0;
      m_alarm = 0;
      m_ovr   = 0;
      m_en    = 1;
    end else if (m_en) begin
      done = 0;
      s    = 0;
      r    = 0;
      if (bus.in_valid) begin
        q_win.push_back(bus.in);
        if (q_win.size() == WIN_LEN) begin
          done = 1;
          s    = win_sum();
          r    = win_maxrun();
          q_win.delete();
        end
      end
      if (done) begin
        if (!m_cv || bus.ack) begin
          m_count = s;
          m_mr    = MrEn ? r : 0;
          m_alarm = (s >= THRESH);
          m_cv    = 1;
        end else begin
          m_ovr = 1;
        end
      end else if (bus.ack && m_cv) begin
        m_cv    = 0;
        m_alarm = 0;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (m_en) begin
      chk("cyc_count",       bus.count,       m_count);
      chk("cyc_max_run",     bus.max_run,     m_mr);
      chk("cyc_count_valid", bus.count_valid, m_cv);
      chk("cyc_alarm",       bus.alarm,       m_alarm);
      chk("cyc_overrun",     bus.overrun,     m_ovr);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input bit b, input bit a);
    @(negedge clk);
    reset        = 1'b0;
    bus.in_valid = v;
    bus.in       = b;
    bus.ack      = a;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in       = 1'b0;
    bus.ack      = 1'b0;
  endtask

  // Sample i of the window is pat[i-1]; ack_last raises ack on the completing sample.
  task automatic run_window(input logic [15:0] pat, input bit gaps, input bit ack_last,
                            input bit hold_cv);
    for (int i = 0; i < WIN_LEN; i++) begin
      if (gaps) drive(1'b0, 1'b1, 1'b0);
      drive(1'b1, pat[i], (i == WIN_LEN - 1) && ack_last);
      if (hold_cv) chk("cv_hold", bus.count_valid, 1);
    end
    drive(1'b0, 1'b0, 1'b0);
    if (hold_cv) chk("cv_hold", bus.count_valid, 1);
  endtask

  task automatic chk_result(input string tag, input int c, input int mr, input int al,
                            input int cv, input int ov);
    chk({tag, "_count"},       bus.count,       c);
    chk({tag, "_max_run"},     bus.max_run,     MrEn ? mr : 0);
    chk({tag, "_alarm"},       bus.alarm,       al);
    chk({tag, "_count_valid"}, bus.count_valid, cv);
    chk({tag, "_overrun"},     bus.overrun,     ov);
  endtask

  initial begin
    reset        = 1'b1;
    bus.in       = 1'b0;
    bus.in_valid = 1'b0;
    bus.ack      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_result("reset", 0, 0, 0, 0, 0);

    // Window with alarm: ones at samples 3,4,5,10
    run_window(16'h021C, 1'b0, 1'b0, 1'b0);
    chk_result("win1", 4, 3, 1, 1, 0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      chk("win1_hold_count", bus.count, 4);
      chk("win1_hold_cv", bus.count_valid, 1);
    end
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    chk_result("win1_ack", 4, 3, 0, 0, 0);
    drive(1'b0, 1'b0, 1'b1); // ack with nothing pending
    drive(1'b0, 1'b0, 1'b0);
    chk_result("ack_idle", 4, 3, 0, 0, 0);

    // Gaps with in=1 must not be counted
    run_window(16'h021C, 1'b1, 1'b0, 1'b0);
    chk_result("gaps", 4, 3, 1, 1, 0);

    // Continuous ack on completion: 0, 16, 3 mismatches
    run_window(16'h0000, 1'b0, 1'b1, 1'b1);
    chk_result("cont0", 0, 0, 0, 1, 0);
    run_window(16'hFFFF, 1'b0, 1'b1, 1'b1);
    chk_result("cont1", 16, 16, 1, 1, 0);
    run_window(16'h0111, 1'b0, 1'b1, 1'b1);
    chk_result("cont2", 3, 1, 0, 1, 0);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    chk_result("cont_ack", 3, 1, 0, 0, 0);

    // Overrun: A (5) kept, B (9) dropped
    run_window(16'h001F, 1'b0, 1'b0, 1'b0);
    chk_result("ovrA", 5, 5, 1, 1, 0);
    run_window(16'h01FF, 1'b0, 1'b0, 1'b0);
    chk_result("ovrB", 5, 5, 1, 1, 1);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    chk_result("ovr_ack", 5, 5, 0, 0, 1);

    // Reset mid-window discards the partial window
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b0);
    do_reset();
    drive(1'b0, 1'b0, 1'b0);
    chk_result("mid_rst", 0, 0, 0, 0, 0);
    run_window(16'h0000, 1'b0, 1'b0, 1'b0);
    chk_result("post_rst", 0, 0, 0, 1, 0);

    repeat (3) drive(1'b0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
